md5_core_arbiter: RTL and testbench
===================================

# md5_core_arbiter

Round-robin arbiter and sequencer that shares one non-pipelined md5core between NUM_REQ string-window requesters inside string_process_match. It grants one requester at a time, launches the core with that requester's padded message, and compares the returned digest against the target hash held by cmd_parser. Per-requester response pulses and a sticky first-match record are returned upstream so cmd_parser can ACK the host over the UART.

## Interface

**Parameters**
- NUM_REQ, 4: number of requesters; must be ≥2.
- ID_W, 2: requester index width; must equal clog2(NUM_REQ).
- MSG_BITS, 512: width of one padded md5 block.
- TIMEOUT_CYC, 255: maximum number of WAIT cycles before the request is abandoned.

**Ports**
- clk, input, 1: single clock for the whole block.
- reset, input, 1: asynchronous, active-high.
- req, input, NUM_REQ: per-requester request level. Each requester holds it until it sees its gnt bit.
- req_msg, input, NUM_REQ*MSG_BITS: requester i's message occupies bits [i*MSG_BITS +: MSG_BITS].
- gnt, output, NUM_REQ: one-hot, one-cycle grant pulse.
- rsp_valid, output, NUM_REQ: one-hot, one-cycle result pulse.
- rsp_match, output, 1: digest equalled target_hash. Qualified by rsp_valid.
- rsp_timeout, output, 1: request was abandoned by the watchdog. Qualified by rsp_valid.
- target_hash, input, 128: target digest. Sampled only in the cycle core_done is accepted.
- core_start, output, 1: one-cycle start pulse to md5core.
- core_msg, output, MSG_BITS: message latched at grant. Held stable from grant until the next grant.
- core_done, input, 1: md5core completion pulse.
- core_digest, input, 128: md5core digest. Valid with core_done.
- match_flag, output, 1: sticky; set on the first match since reset or clear.
- match_id, output, ID_W: requester index of the first match.
- match_count, output, 16: number of matches; saturates at 16'hFFFF.
- match_clear, input, 1: clears match_flag, match_id and match_count.
- busy, output, 1: high in every state except IDLE.

## Operation

**State machine:** IDLE → GRANT → WAIT → RESP → IDLE.
- **IDLE**
  - If req is nonzero, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch the winner's index into cur_id and its message into core_msg. Go to GRANT.
  - If req is zero, stay in IDLE.
- **GRANT** (exactly one cycle)
  - gnt[cur_id]=1 and core_start=1. Clear the watchdog counter. Go to WAIT.
- **WAIT**
  - On core_done: register (core_digest == target_hash) into a match bit, clear the timeout bit, go to RESP.
  - Otherwise increment the watchdog. When it reaches TIMEOUT_CYC, set the timeout bit, clear the match bit, go to RESP.
- **RESP** (exactly one cycle)
  - rsp_valid[cur_id]=1, with rsp_match and rsp_timeout driven from the registered bits.
  - If the match bit is set: increment match_count (saturating). If match_flag is 0, set match_flag and load match_id=cur_id.
  - Set rr_ptr = (cur_id+1) mod NUM_REQ. Go to IDLE.

**Boundary rules**
- req is ignored outside IDLE. The granted requester drops req after gnt, so it cannot be re-selected before RESP.
- core_done outside WAIT is ignored, including a late done after a timeout.
- match_clear in the same cycle as a RESP match: the match wins. Result is match_flag=1, match_id=cur_id, match_count=1.
- match_count at 16'hFFFF stays at 16'hFFFF.
- A single requester that is continuously active is served every round.
- With all requesters active, service order is rr_ptr, rr_ptr+1, …, wrapping.
- Reset mid-operation returns the block to IDLE in the same instant. The core is not notified; any pending core_done is ignored.

## Timing

**Reset values**
- All outputs 0: gnt, rsp_valid, rsp_match, rsp_timeout, core_start, core_msg, match_flag, match_id, match_count, busy.
- Internal rr_ptr=0 and state=IDLE.

**Latency**
- req sampled high in IDLE at edge N → gnt/core_start high in cycle N+1.
- core_done sampled at edge M → rsp_valid high in cycle M+1.
- Back-to-back throughput with core latency L (start to done): one request per L+3 cycles.

**Handshakes**
- gnt and core_start are always coincident.
- rsp_valid is never asserted in the same cycle as gnt.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

Bench setup: core model with L=64 that returns the digest a2004f37730b9445670a738fa0fc9ee5 only for message tag 0xA5, and 0 otherwise.

1. **Single request, match.** target_hash = a2004f37730b9445670a738fa0fc9ee5, req=4'b0010 with tag 0xA5 → gnt=4'b0010 one cycle after req; rsp_valid=4'b0010 at core_done+1 with rsp_match=1; match_flag=1, match_id=1, match_count=1.
2. **All requesters active, rr_ptr=0.** req=4'b1111 held → grant order 0,1,2,3,0; consecutive grants 67 cycles apart.
3. **Watchdog.** Core model never asserts done → rsp_valid at GRANT+TIMEOUT_CYC+2 with rsp_timeout=1 and rsp_match=0. A late core_done is then ignored: no extra rsp_valid.
4. **Multiple matches and clear.** Requesters 2 then 3 both match → match_id stays 2, match_count=2. Pulse match_clear → all three cleared. match_clear coincident with a RESP match → match_flag=1, match_count=1.
5. **Reset mid-WAIT.** Assert reset 10 cycles after core_start → all outputs 0 immediately. After reset release, a new req=4'b0001 is granted from rr_ptr=0.
6. **Saturation.** Preload match_count via 65 540 back-to-back matches → match_count=16'hFFFF and holds.

Source files
------------

// File: rtl/md5_core_arbiter.sv
// rtl/md5_core_arbiter.sv - round-robin arbiter sharing one md5core between string-window requesters
module md5_core_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int MSG_BITS    = 512,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*MSG_BITS-1:0] req_msg,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic                        rsp_match,
    output logic                        rsp_timeout,
    input  logic [127:0]                target_hash,
    output logic                        core_start,
    output logic [MSG_BITS-1:0]         core_msg,
    input  logic                        core_done,
    input  logic [127:0]                core_digest,
    output logic                        match_flag,
    output logic [ID_W-1:0]             match_id,
    output logic [15:0]                 match_count,
    input  logic                        match_clear,
    output logic                        busy
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] idx;
    logic            found;
    logic [WD_W-1:0] wd_cnt;
    logic            match_bit;
    logic            timeout_bit;
    logic            wd_expired;

    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC));

    // First set request at or above rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = GRANT;
            GRANT:   state_nxt = WAIT;
            WAIT:    if (core_done || wd_expired) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt         = '0;
        rsp_valid   = '0;
        core_start  = 1'b0;
        rsp_match   = 1'b0;
        rsp_timeout = 1'b0;
        busy        = (state != IDLE);
        case (state)
            GRANT: begin
                gnt[cur_id] = 1'b1;
                core_start  = 1'b1;
            end
            RESP: begin
                rsp_valid[cur_id] = 1'b1;
                rsp_match         = match_bit;
                rsp_timeout       = timeout_bit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_id      <= '0;
            rr_ptr      <= '0;
            core_msg    <= '0;
            wd_cnt      <= '0;
            match_bit   <= 1'b0;
            timeout_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cur_id   <= win_id;
                        core_msg <= req_msg[win_id*MSG_BITS +: MSG_BITS];
                    end
                end
                GRANT: wd_cnt <= '0;
                WAIT: begin
                    // done takes priority over an expiring watchdog in the same cycle
                    if (core_done) begin
                        match_bit   <= (core_digest == target_hash);
                        timeout_bit <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_expired) begin
                            timeout_bit <= 1'b1;
                            match_bit   <= 1'b0;
                        end
                    end
                end
                RESP: rr_ptr <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
                default: ;
            endcase
        end
    end

    // A match reported in the same cycle as match_clear restarts the record with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_flag  <= 1'b0;
            match_id    <= '0;
            match_count <= '0;
        end else if (state == RESP && match_bit) begin
            if (match_clear) begin
                match_flag  <= 1'b1;
                match_id    <= cur_id;
                match_count <= 16'd1;
            end else begin
                if (!match_flag) begin
                    match_flag <= 1'b1;
                    match_id   <= cur_id;
                end
                if (match_count != 16'hFFFF) match_count <= match_count + 16'd1;
            end
        end else if (match_clear) begin
            match_flag  <= 1'b0;
            match_id    <= '0;
            match_count <= '0;
        end
    end
endmodule

// File: tb/tb_md5_core_arbiter.sv
// tb/tb_md5_core_arbiter.sv - directed vector bench for md5_core_arbiter
module tb_md5_core_arbiter;
    localparam int NR = 4;
    localparam int MB = 512;
    localparam int L  = 64;
    localparam logic [127:0] HASH = 128'ha2004f37730b9445670a738fa0fc9ee5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*MB-1:0] req_msg = '0;
    logic [NR-1:0]   gnt, rsp_valid;
    logic            rsp_match, rsp_timeout, core_start, core_done, match_flag, busy;
    logic [127:0]    target_hash = '0;
    logic [MB-1:0]   core_msg;
    logic [127:0]    core_digest;
    logic [1:0]      match_id;
    logic [15:0]     match_count;
    logic            match_clear = 1'b0;

    md5_core_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_msg(req_msg), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_match(rsp_match), .rsp_timeout(rsp_timeout),
        .target_hash(target_hash), .core_start(core_start), .core_msg(core_msg),
        .core_done(core_done), .core_digest(core_digest), .match_flag(match_flag),
        .match_id(match_id), .match_count(match_count), .match_clear(match_clear),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // md5core model: done L cycles after start, digest HASH only for tag 0xA5
    logic [6:0] cnt = '0;
    bit         core_en = 1'b1;
    logic       late_done = 1'b0;
    always @(posedge clk) begin
        if (core_start) cnt <= 7'(L);
        else if (cnt != 0) cnt <= cnt - 7'd1;
    end
    assign core_done   = (core_en && cnt == 7'd1) || late_done;
    assign core_digest = (core_msg[7:0] == 8'hA5) ? HASH : 128'h0;

    int nvec = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_msgs(input logic [7:0] tag);
        for (int i = 0; i < NR; i++) req_msg[i*MB +: MB] = {8'(i + 1), 496'h0, tag};
    endtask

    task automatic wait_gnt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (|gnt) ok = 1'b1;
        end
    endtask

    task automatic wait_rsp(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (|rsp_valid) ok = 1'b1;
        end
    endtask

    task automatic txn(input logic [3:0] r, input bit clr,
                       output logic [3:0] g, output logic cs, output logic [7:0] cm,
                       output int gc, output int lat, output logic [3:0] rv,
                       output logic rm, output logic rt, output int rc);
        bit ok;
        int c0;
        c0  = cyc;
        req = r;
        wait_gnt(300, ok);
        chk("gnt_seen", 128'(ok), 128'd1);
        g = gnt; cs = core_start; cm = core_msg[511:504]; gc = cyc; lat = gc - c0;
        req = '0;
        wait_rsp(400, ok);
        chk("rsp_seen", 128'(ok), 128'd1);
        rv = rsp_valid; rm = rsp_match; rt = rsp_timeout; rc = cyc;
        if (clr) match_clear = 1'b1;
        @(negedge clk);
        match_clear = 1'b0;
    endtask

    task automatic pulse_clear();
        match_clear = 1'b1;
        @(negedge clk);
        match_clear = 1'b0;
    endtask

    function automatic int oh2i(input logic [3:0] o);
        for (int i = 0; i < 4; i++) if (o[i]) return i;
        return 0;
    endfunction

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  tag;
        logic        hit_tgt;
        logic [3:0]  exp_gnt;
        logic        exp_match;
        logic        exp_flag;
        logic [1:0]  exp_id;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [3:0] g, rv;
        logic cs, rm, rt;
        logic [7:0] cm;
        int gc, lat, rc, prev, extra;
        bit ok;

        tbl[0] = '{4'b0010, 8'hA5, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 16'd1};
        tbl[1] = '{4'b0001, 8'h00, 1'b1, 4'b0001, 1'b0, 1'b1, 2'd1, 16'd1};
        tbl[2] = '{4'b1001, 8'hA5, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd1, 16'd2};
        tbl[3] = '{4'b1001, 8'hA5, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd1, 16'd2};
        tbl[4] = '{4'b0001, 8'h00, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd1, 16'd3};
        tbl[5] = '{4'b0110, 8'h5A, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 16'd3};

        repeat (2) @(negedge clk);
        chk("rst_gnt", 128'(gnt), 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_rsp_flags", 128'({rsp_match, rsp_timeout, core_start, busy}), 128'd0);
        chk("rst_core_msg", 128'(core_msg != '0), 128'd0);
        chk("rst_match", 128'({match_flag, match_id, match_count}), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            set_msgs(tbl[v].tag);
            target_hash = tbl[v].hit_tgt ? HASH : 128'h0;
            txn(tbl[v].req, 1'b0, g, cs, cm, gc, lat, rv, rm, rt, rc);
            chk($sformatf("v%0d_gnt_lat", v), 128'(lat), 128'd1);
            chk($sformatf("v%0d_gnt", v), 128'(g), 128'(tbl[v].exp_gnt));
            chk($sformatf("v%0d_core_start", v), 128'(cs), 128'd1);
            chk($sformatf("v%0d_core_msg", v), 128'(cm), 128'(oh2i(tbl[v].exp_gnt) + 1));
            chk($sformatf("v%0d_rsp_lat", v), 128'(rc - gc), 128'(L + 1));
            chk($sformatf("v%0d_rsp_valid", v), 128'(rv), 128'(tbl[v].exp_gnt));
            chk($sformatf("v%0d_rsp_match", v), 128'({rm, rt}), 128'({tbl[v].exp_match, 1'b0}));
            chk($sformatf("v%0d_flag_id", v), 128'({match_flag, match_id}), 128'({tbl[v].exp_flag, tbl[v].exp_id}));
            chk($sformatf("v%0d_count", v), 128'(match_count), 128'(tbl[v].exp_cnt));
            chk($sformatf("v%0d_busy", v), 128'(busy), 128'd0);
        end

        // multiple matches, clear, and clear coincident with a match
        pulse_clear();
        chk("clr1", 128'({match_flag, match_id, match_count}), 128'd0);
        set_msgs(8'hA5);
        target_hash = HASH;
        txn(4'b0100, 1'b0, g, cs, cm, gc, lat, rv, rm, rt, rc);
        txn(4'b1000, 1'b0, g, cs, cm, gc, lat, rv, rm, rt, rc);
        chk("multi_id", 128'({match_flag, match_id}), 128'({1'b1, 2'd2}));
        chk("multi_count", 128'(match_count), 128'd2);
        txn(4'b0010, 1'b1, g, cs, cm, gc, lat, rv, rm, rt, rc);
        chk("clr_coinc", 128'({match_flag, match_id, match_count}), 128'({1'b1, 2'd1, 16'd1}));
        pulse_clear();
        chk("clr2", 128'({match_flag, match_id, match_count}), 128'd0);

        // watchdog and late done
        core_en = 1'b0;
        txn(4'b0100, 1'b0, g, cs, cm, gc, lat, rv, rm, rt, rc);
        chk("wd_lat", 128'(rc - gc), 128'd257);
        chk("wd_rsp", 128'({rv, rm, rt}), 128'({4'b0100, 1'b0, 1'b1}));
        core_en = 1'b1;
        late_done = 1'b1;
        @(negedge clk);
        late_done = 1'b0;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (|rsp_valid || busy) extra++;
        end
        chk("late_done_ignored", 128'(extra), 128'd0);

        // reset mid-WAIT
        req = 4'b0100;
        wait_gnt(300, ok);
        req = '0;
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", 128'(busy), 128'd1);
        reset = 1'b1;
        #1;
        chk("midrst_busy_gnt", 128'({busy, gnt, rsp_valid, core_start}), 128'd0);
        chk("midrst_core_msg", 128'(core_msg != '0), 128'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (70) begin
            @(negedge clk);
            if (|rsp_valid || busy) extra++;
        end
        chk("pending_done_ignored", 128'(extra), 128'd0);

        // all requesters active from rr_ptr=0
        req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(200, ok);
            chk($sformatf("rr%0d_seen", k), 128'(ok), 128'd1);
            chk($sformatf("rr%0d_gnt", k), 128'(gnt), 128'(4'b0001 << (k % 4)));
            if (k > 0) chk($sformatf("rr%0d_spacing", k), 128'(cyc - prev), 128'd67);
            prev = cyc;
        end
        req = '0;
        wait_rsp(200, ok);
        @(negedge clk);
        chk("rr_count", 128'({match_flag, match_id, match_count}), 128'({1'b1, 2'd0, 16'd5}));

        // saturation from a preloaded count
        force dut.match_count = 16'hFFFD;
        @(negedge clk);
        release dut.match_count;
        for (int k = 0; k < 3; k++) begin
            txn(4'b0001, 1'b0, g, cs, cm, gc, lat, rv, rm, rt, rc);
            chk($sformatf("sat%0d", k), 128'(match_count), (k == 0) ? 128'hFFFE : 128'hFFFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
